upc_checkout_ctrl: RTL and testbench
====================================

// Module: upc_checkout_ctrl
// PURPOSE
//  Sequences the UPC checker for a checkout lane. Captures a UPC code and secret mark on each scan press
//  and presents them, registered, to the external combinational checker. One cycle later it samples the
//  checker's discounted/stolen verdict and keeps running item/discount/stolen tallies.
//  A stolen verdict latches a lane alarm until the operator clears it. Sits between the board top level
//  (SW/KEY/LEDR) and the checker.
// PARAMETERS
//  COUNT_W   4  width of each tally counter; counters saturate at 2**COUNT_W-1
//  SYNC_EN   1  1: scan/clear pass through 2-flop synchronizers; 0: inputs treated as already synchronous
// PORTS
//  clk            in   1        system clock (CLOCK_50 at top level)
//  reset_n        in   1        asynchronous, active-low reset
//  scan           in   1        active-high scan request (top level drives ~KEY[0]); async when SYNC_EN=1
//  clear          in   1        active-high operator clear (top level drives ~KEY[1]); async when SYNC_EN=1
//  upc_in         in   3        UPC code {U,P,C} from SW[8:6]
//  mark_in        in   1        secret mark from SW[0]
//  discounted_in  in   1        checker verdict for upc_q/mark_q
//  stolen_in      in   1        checker verdict for upc_q/mark_q
//  upc_q          out  3        registered UPC driven to checker and display
//  mark_q         out  1        registered mark driven to checker
//  busy           out  1        high in LATCH/EVAL; high means a scan is in flight
//  done           out  1        one-cycle pulse in the cycle the verdict is sampled (EVAL)
//  alarm          out  1        high while FSM is in ALARM
//  item_cnt       out  COUNT_W  items scanned
//  disc_cnt       out  COUNT_W  items judged discounted
//  stolen_cnt     out  COUNT_W  items judged stolen
// BEHAVIOUR
//  Reset (reset_n low, async): FSM=IDLE; upc_q=0, mark_q=0, busy=0, done=0, alarm=0.
//   All counters=0. Synchronizer/edge flops=0.
//  Edge detect: scan_rise/clear_rise = 1-cycle pulse on the 0->1 transition of the synchronized signal.
//   SYNC_EN=1: pulse occurs 2 clk edges after scan is first sampled high. SYNC_EN=0: occurs 1 clk edge after.
//   Holding scan high yields exactly one pulse.
//  FSM states:
//   IDLE : on scan_rise -> LATCH; the same edge loads upc_q<=upc_in and mark_q<=mark_in.
//   LATCH: busy=1. Unconditional -> EVAL; gives the checker one full cycle to settle on upc_q/mark_q.
//   EVAL : busy=1, done=1. Sample discounted_in/stolen_in. item_cnt+=1; disc_cnt+=discounted_in;
//          stolen_cnt+=stolen_in. All increments saturate.
//          stolen_in=1 -> ALARM, else -> IDLE.
//   ALARM: alarm=1. scan_rise ignored (no capture, no count). clear_rise -> IDLE; counters untouched.
//  Latency: 2 cycles from scan_rise to done.
//  clear_rise in IDLE: all three counters <= 0 on that edge; upc_q/mark_q hold.
//  clear_rise in LATCH/EVAL: ignored; the in-flight item completes normally.
//  scan_rise in LATCH/EVAL: dropped, not queued.
//  scan_rise and clear_rise in the same IDLE cycle: clear wins (counters zeroed, no capture); scan is dropped.
//  upc_in/mark_in changes after capture do not affect the current item.
//  Saturation: a counter at all-ones stays all-ones; other counters still increment.
//  reset_n low mid-operation: immediate return to reset values; the in-flight item is not counted.
// TESTING
//  1. Reset, upc_in=3'b011, mark_in=0, pulse scan -> done 2 cyc after scan_rise; item_cnt=1, disc_cnt=1,
//     stolen_cnt=0, alarm=0.
//  2. upc_in=3'b000, mark_in=0, scan -> stolen_in=1 -> alarm=1, stolen_cnt=1. Second scan ignored
//     (item_cnt unchanged). clear -> IDLE, alarm=0, counters held.
//  3. upc_in=3'b101, mark_in=0, scan -> disc_cnt and stolen_cnt both +1; alarm=1.
//     Change SW during LATCH -> upc_q stays 3'b101.
//  4. COUNT_W=2: 5 scans of 3'b011/mark=0 -> item_cnt=3, disc_cnt=3 (saturated).
//     Then clear in IDLE -> all counters 0.
//  5. Hold scan high 20 cycles -> exactly 1 item counted. scan and clear same IDLE cycle -> counters 0,
//     no capture.
//  6. Assert reset_n low during EVAL -> all outputs at reset values before next clk edge;
//     item_cnt=0 after release.

Source files
------------

// File: rtl/upc_checkout_ctrl.sv
// -----------------------------------------------------------------------------
// upc_checkout_ctrl
//
// Checkout-lane sequencer for the UPC checker. A scan press captures the UPC
// code and secret mark into registers that feed the external combinational
// checker. The checker gets one full cycle to settle. Its verdict is then
// sampled into saturating item / discounted / stolen tallies. A stolen verdict
// parks the lane in an alarm state until the operator presses clear.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous, active-low reset
//   scan           active-high scan request (asynchronous when SYNC_EN=1)
//   clear          active-high operator clear (asynchronous when SYNC_EN=1)
//   upc_in[2:0]    UPC code {U,P,C}
//   mark_in        secret mark
//   discounted_in  checker verdict for upc_q/mark_q
//   stolen_in      checker verdict for upc_q/mark_q
//   upc_q[2:0]     registered UPC code driven to the checker and display
//   mark_q         registered mark driven to the checker
//   busy           a scan is in flight (LATCH or EVAL)
//   done           one-cycle pulse in the cycle the verdict is sampled
//   alarm          lane alarm, high while in ALARM
//   item_cnt       items scanned (saturating)
//   disc_cnt       items judged discounted (saturating)
//   stolen_cnt     items judged stolen (saturating)
//   state_dbg[1:0] current FSM state (IDLE=0, LATCH=1, EVAL=2, ALARM=3)
//
// Request/response semantics: scan and clear are edge requests. Only the
// 0->1 transition of the synchronized level counts, so holding a key gives a
// single request. A scan edge is accepted only in IDLE. Scan edges that arrive
// while busy=1 or alarm=1 are dropped, not queued. Every accepted scan produces
// exactly one done pulse two cycles after its edge. The tallies reflect that
// item from the cycle after done.
// -----------------------------------------------------------------------------
module upc_checkout_ctrl #(
    parameter int COUNT_W = 4,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan,
    input  logic               clear,
    input  logic [2:0]         upc_in,
    input  logic               mark_in,
    input  logic               discounted_in,
    input  logic               stolen_in,
    output logic [2:0]         upc_q,
    output logic               mark_q,
    output logic               busy,
    output logic               done,
    output logic               alarm,
    output logic [COUNT_W-1:0] item_cnt,
    output logic [COUNT_W-1:0] disc_cnt,
    output logic [COUNT_W-1:0] stolen_cnt,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        EVAL  = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    state_t state;
    state_t state_nx;

    // ------------------------------------------------------------------
    // Input conditioning.
    // *_m is the metastability stage. *_s is the synchronized level. *_d is
    // that level one cycle later, used for edge detection. With SYNC_EN=0 the
    // metastability stage is bypassed. The level is still registered once, so
    // the edge pulse lands one edge after the input is first sampled high.
    // ------------------------------------------------------------------
    logic scan_m, scan_s, scan_d;
    logic clear_m, clear_s, clear_d;
    logic scan_rise, clear_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_m  <= 1'b0;
            scan_s  <= 1'b0;
            scan_d  <= 1'b0;
            clear_m <= 1'b0;
            clear_s <= 1'b0;
            clear_d <= 1'b0;
        end else begin
            scan_m  <= scan;
            clear_m <= clear;
            scan_s  <= SYNC_EN ? scan_m  : scan;
            clear_s <= SYNC_EN ? clear_m : clear;
            scan_d  <= scan_s;
            clear_d <= clear_s;
        end
    end

    assign scan_rise  = scan_s  & ~scan_d;
    assign clear_rise = clear_s & ~clear_d;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath strobes
    // ------------------------------------------------------------------
    logic capture;     // load upc_q/mark_q from the switches
    logic cnt_clear;   // zero all tallies
    logic cnt_update;  // fold the checker verdict into the tallies

    always_comb begin
        state_nx   = state;
        capture    = 1'b0;
        cnt_clear  = 1'b0;
        cnt_update = 1'b0;
        case (state)
            IDLE: begin
                // Clear has priority. A scan arriving in the same cycle is lost.
                if (clear_rise) begin
                    cnt_clear = 1'b1;
                end else if (scan_rise) begin
                    capture  = 1'b1;
                    state_nx = LATCH;
                end
            end
            LATCH: begin
                // Settling cycle for the external checker on the new upc_q/mark_q.
                state_nx = EVAL;
            end
            EVAL: begin
                cnt_update = 1'b1;
                state_nx   = stolen_in ? ALARM : IDLE;
            end
            ALARM: begin
                if (clear_rise) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy      = (state == LATCH) || (state == EVAL);
    assign done      = (state == EVAL);
    assign alarm     = (state == ALARM);
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Captured item. This register holds through LATCH/EVAL, so switch
    // activity after the scan cannot disturb the item being judged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upc_q  <= 3'b000;
            mark_q <= 1'b0;
        end else if (capture) begin
            upc_q  <= upc_in;
            mark_q <= mark_in;
        end
    end

    // ------------------------------------------------------------------
    // Saturating tallies. Each counter saturates on its own, so a full
    // item_cnt does not stop disc_cnt or stolen_cnt from advancing.
    // ------------------------------------------------------------------
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                   input logic               en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            item_cnt   <= '0;
            disc_cnt   <= '0;
            stolen_cnt <= '0;
        end else if (cnt_clear) begin
            item_cnt   <= '0;
            disc_cnt   <= '0;
            stolen_cnt <= '0;
        end else if (cnt_update) begin
            item_cnt   <= sat_inc(item_cnt,   1'b1);
            disc_cnt   <= sat_inc(disc_cnt,   discounted_in);
            stolen_cnt <= sat_inc(stolen_cnt, stolen_in);
        end
    end

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
module tb_upc_checkout_ctrl;

  localparam int CW   = 2;
  localparam int W    = 4 + 3 * CW;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          scan = 1'b0;
  logic          clear = 1'b0;
  logic [2:0]    upc_in = 3'b000;
  logic          mark_in = 1'b0;
  logic          discounted_in;
  logic          stolen_in;
  logic [2:0]    upc_q;
  logic          mark_q;
  logic          busy;
  logic          done;
  logic          alarm;
  logic [CW-1:0] item_cnt;
  logic [CW-1:0] disc_cnt;
  logic [CW-1:0] stolen_cnt;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  upc_checkout_ctrl #(.COUNT_W(CW), .SYNC_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .scan(scan), .clear(clear),
    .upc_in(upc_in), .mark_in(mark_in),
    .discounted_in(discounted_in), .stolen_in(stolen_in),
    .upc_q(upc_q), .mark_q(mark_q), .busy(busy), .done(done), .alarm(alarm),
    .item_cnt(item_cnt), .disc_cnt(disc_cnt), .stolen_cnt(stolen_cnt),
    .state_dbg(state_dbg)
  );

  // External checker stand-in: discounted = U | P&C, stolen = ~M & ~(P&C)
  function automatic bit chk_disc(input logic [2:0] u);
    return u[2] | (u[1] & u[0]);
  endfunction
  function automatic bit chk_stolen(input logic [2:0] u, input logic m);
    return !m && !(u[1] & u[0]);
  endfunction

  assign discounted_in = chk_disc(upc_q);
  assign stolen_in     = chk_stolen(upc_q, mark_q);

  // ---------------- scoreboard bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A request edge acts two clocks after the key is first sampled high.
  // An accepted scan is judged two clocks later.
  int         m_item = 0, m_disc = 0, m_stolen = 0;
  int         m_left = 0;        // clocks until the verdict of the item in flight
  bit         m_alarm = 1'b0;
  logic [2:0] m_upc = 3'b000;
  logic       m_mark = 1'b0;
  logic [2:0] s_hist = 3'b000;   // [0] newest sample of scan
  logic [2:0] c_hist = 3'b000;

  function automatic int sat(input int v, input bit en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_item = 0; m_disc = 0; m_stolen = 0; m_left = 0; m_alarm = 1'b0;
      m_upc = 3'b000; m_mark = 1'b0; s_hist = 3'b000; c_hist = 3'b000;
      exp_q.delete();
    end else begin
      bit rs, rc, d, s;
      rs = s_hist[1] & ~s_hist[2];
      rc = c_hist[1] & ~c_hist[2];
      s_hist = {s_hist[1:0], scan};
      c_hist = {c_hist[1:0], clear};
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          d = chk_disc(m_upc);
          s = chk_stolen(m_upc, m_mark);
          m_item   = sat(m_item, 1'b1);
          m_disc   = sat(m_disc, d);
          m_stolen = sat(m_stolen, s);
          if (s) m_alarm = 1'b1;
        end
      end else if (m_alarm) begin
        if (rc) m_alarm = 1'b0;
      end else if (rc) begin
        m_item = 0; m_disc = 0; m_stolen = 0;
      end else if (rs) begin
        m_upc  = upc_in;
        m_mark = mark_in;
        m_left = 2;
        d = chk_disc(upc_in);
        s = chk_stolen(upc_in, mark_in);
        exp_q.push_back({upc_in, mark_in, CW'(sat(m_item, 1'b1)),
                         CW'(sat(m_disc, d)), CW'(sat(m_stolen, s))});
      end
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] pend = '0;
  bit           pend_v = 1'b0;

  always @(negedge clk) begin
    if (!reset_n || !mon_en) begin
      pend_v = 1'b0;
    end else begin
      logic [W-1:0] rec;
      chk("busy",       busy,       32'(m_left > 0));
      chk("done",       done,       32'(m_left == 1));
      chk("alarm",      alarm,      32'(m_alarm));
      chk("item_cnt",   item_cnt,   m_item);
      chk("disc_cnt",   disc_cnt,   m_disc);
      chk("stolen_cnt", stolen_cnt, m_stolen);
      if (pend_v) begin
        chk("item_after_done",   item_cnt,   pend[3*CW-1 -: CW]);
        chk("disc_after_done",   disc_cnt,   pend[2*CW-1 -: CW]);
        chk("stolen_after_done", stolen_cnt, pend[CW-1:0]);
        pend_v = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          rec = exp_q.pop_front();
          chk("upc_q_at_done",  upc_q,  rec[W-1 -: 3]);
          chk("mark_q_at_done", mark_q, rec[3*CW]);
          pend   = rec;
          pend_v = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] u, input logic m, input int hold);
    @(negedge clk);
    upc_in = u; mark_in = m; scan = 1'b1;
    cyc(hold);
    scan = 1'b0;
    cyc(2);
    upc_in = 3'($urandom_range(0, 7));
    mark_in = 1'($urandom_range(0, 1));
    cyc(6);
  endtask

  task automatic clear_press();
    @(negedge clk);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(5);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  scan_left;
    bit  found;
    scan_left = 0;

    reset_n = 1'b0;
    cyc(3);
    chk("rst_upc_q",  upc_q,      0);
    chk("rst_mark_q", mark_q,     0);
    chk("rst_busy",   busy,       0);
    chk("rst_done",   done,       0);
    chk("rst_alarm",  alarm,      0);
    chk("rst_item",   item_cnt,   0);
    chk("rst_disc",   disc_cnt,   0);
    chk("rst_stolen", stolen_cnt, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cyc(2);

    press(3'b011, 1'b0, 1);      // discounted only
    press(3'b000, 1'b0, 1);      // stolen -> alarm
    press(3'b011, 1'b0, 1);      // ignored while in alarm
    clear_press();               // leave alarm, tallies held
    press(3'b101, 1'b0, 1);      // discounted and stolen
    clear_press();               // leave alarm
    clear_press();               // zero tallies in IDLE
    repeat (5) press(3'b011, 1'b0, 1);  // saturate item/disc
    clear_press();
    press(3'b110, 1'b1, 20);     // held key counts once
    @(negedge clk);              // scan and clear together: clear wins
    upc_in = 3'b111; scan = 1'b1; clear = 1'b1;
    cyc(1);
    scan = 1'b0; clear = 1'b0;
    cyc(6);

    repeat (1500) begin
      @(negedge clk);
      if (scan_left == 0) begin
        scan = 1'($urandom_range(0, 1));
        scan_left = $urandom_range(1, 6);
      end
      scan_left--;
      clear   = ($urandom_range(0, 19) == 0);
      upc_in  = 3'($urandom_range(0, 7));
      mark_in = 1'($urandom_range(0, 1));
    end

    // Reset in the middle of EVAL
    @(negedge clk);
    scan = 1'b0; clear = 1'b0;
    cyc(10);
    clear_press();
    cyc(4);
    mon_en = 1'b0;
    @(negedge clk);
    upc_in = 3'b011; mark_in = 1'b0; scan = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("eval_reached", 32'(found), 1);
    scan = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_upc_q", upc_q,    0);
    chk("midrst_busy",  busy,     0);
    chk("midrst_done",  done,     0);
    chk("midrst_alarm", alarm,    0);
    chk("midrst_item",  item_cnt, 0);
    cyc(2);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cyc(4);
    chk("item_after_reset", item_cnt, 0);

    // Drain
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && m_left == 0) found = 1'b1;
    end
    chk("drain", 32'(found), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
